// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: streams a contiguous run of 80-bit weight words from
// the weight SRAM into a small output FIFO drained over valid/ready.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    command strobe (sampled in IDLE only)
//   base_addr, num_words     run parameters, latched on accepted start
//   busy, done               run in progress / one-cycle completion pulse
//   sram_csb, sram_wsb       SRAM chip select / write enable (active-low)
//   sram_raddr, sram_rdata   SRAM read address / data (1-cycle latency)
//   w_valid, w_ready         output handshake
//   w_data, w_last           FIFO head word / last-word-of-run flag
module weight_fetch_ctrl #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 80,
    parameter int LEN_W      = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic              sram_csb,
    output logic              sram_wsb,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic              w_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_FIN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              inflight_q;
    logic              last_inf_q;

    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [CNT_W:0]    occ;
    logic              issue;
    logic              push;
    logic              pop;

    // Credit rule: words buffered plus the word in flight never exceed
    // the FIFO depth, so the returning read always finds a free slot.
    assign occ   = {1'b0, cnt_q} + (CNT_W+1)'(inflight_q);
    assign issue = (state_q == S_FETCH) && (rem_q != '0)
                   && (occ < DEPTH_C);
    assign push  = inflight_q;
    assign pop   = w_valid && w_ready;

    assign sram_csb   = ~issue;
    assign sram_wsb   = 1'b1;
    assign sram_raddr = addr_q;

    assign w_valid = (cnt_q != '0);
    assign w_data  = w_valid ? mem_q[rptr_q][DATA_W-1:0] : '0;
    assign w_last  = w_valid ? mem_q[rptr_q][DATA_W] : 1'b0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = start;
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = num_words;
                    state_d = (num_words == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Finish in the cycle after the final handshake.
                if (!inflight_q && ((cnt_q == '0) ||
                    ((cnt_q == CNT_W'(1)) && pop)))
                    state_d = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            last_inf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= issue;
            last_inf_q <= issue && (rem_q == LEN_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= {last_inf_q, sram_rdata};
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop) rptr_q <= rptr_q + PTR_W'(1);
            if (push && !pop)
                cnt_q <= cnt_q + CNT_W'(1);
            else if (pop && !push)
                cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule
